// File: rtl/sram_responder_pkg.sv
// rtl/sram_responder_pkg.sv - shared bus constants, pipeline types and command decode for sram_responder
package sram_responder_pkg;

  localparam int SRAM_DATA_LEN         = 16;
  localparam int SRAM_ADDR_LEN         = 18;
  localparam int SRAM_MAX_READ_LATENCY = 4;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2
  } cmd_e;

  typedef enum logic {
    STAGE_EMPTY = 1'b0,
    STAGE_VALID = 1'b1
  } stage_state_e;

  typedef enum logic {
    DRV_IDLE  = 1'b0,
    DRV_DRIVE = 1'b1
  } drive_state_e;

  typedef struct packed {
    stage_state_e             state;
    logic                     ub_n;
    logic                     lb_n;
    logic [SRAM_DATA_LEN-1:0] data;
  } rd_entry_t;

  // Write wins over read whenever the chip is enabled with WE_N low.
  function automatic cmd_e decode_cmd(input logic ce_n, input logic we_n, input logic oe_n);
    cmd_e cmd;
    cmd = CMD_IDLE;
    if (!ce_n && !we_n) begin
      cmd = CMD_WRITE;
    end else if (!ce_n && we_n && !oe_n) begin
      cmd = CMD_READ;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - DEPTH-stage shift register of captured read entries with synchronous flush
module sram_rd_pipe
  import sram_responder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  rd_entry_t in_entry,
  output rd_entry_t out_entry,
  output logic      busy
);

  rd_entry_t [DEPTH-1:0] stage_q;
  rd_entry_t [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else begin
      stage_d[0] = in_entry;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (stage_q[i].state == STAGE_VALID) begin
        busy = 1'b1;
      end
    end
  end

  assign out_entry = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - cycle-based stand-in for the external 16-bit SRAM chip
// Optional protocol checker enabled by defining SRAM_PROTOCOL_CHECK_EN.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int MEM_DEPTH_LOG2 = 16,
  parameter int READ_LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
  input  logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
  input  logic                     SRAM_UB_N,
  input  logic                     SRAM_LB_N,
  input  logic                     SRAM_WE_N,
  input  logic                     SRAM_CE_N,
  input  logic                     SRAM_OE_N,
  output logic [15:0]              rd_count,
  output logic [15:0]              wr_count,
  output logic                     violation,
  output logic [7:0]               violation_count
);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > SRAM_MAX_READ_LATENCY ||
        MEM_DEPTH_LOG2 < 1 || MEM_DEPTH_LOG2 > SRAM_ADDR_LEN) begin : g_bad_param
      $fatal(1, "sram_responder: READ_LATENCY must be 1..4 and MEM_DEPTH_LOG2 1..18");
    end
    if (MEM_DEPTH_LOG2 < SRAM_ADDR_LEN) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^SRAM_ADDR[SRAM_ADDR_LEN-1:MEM_DEPTH_LOG2];
    end
  endgenerate

  localparam int MEM_WORDS = 1 << MEM_DEPTH_LOG2;

  logic [SRAM_DATA_LEN-1:0]  mem_q [MEM_WORDS];
  logic [MEM_DEPTH_LOG2-1:0] mem_idx;
  cmd_e                      cmd;
  logic                      is_read;
  logic                      is_write;
  logic                      wr_hi;
  logic                      wr_lo;

  // Commands seen while rst is high are neither performed nor counted.
  always_comb begin
    cmd      = decode_cmd(SRAM_CE_N, SRAM_WE_N, SRAM_OE_N);
    is_read  = !rst && (cmd == CMD_READ);
    is_write = !rst && (cmd == CMD_WRITE);
    wr_hi    = is_write && !SRAM_UB_N;
    wr_lo    = is_write && !SRAM_LB_N;
    mem_idx  = SRAM_ADDR[MEM_DEPTH_LOG2-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_hi) begin
      mem_q[mem_idx][15:8] <= SRAM_DQ[15:8];
    end
    if (wr_lo) begin
      mem_q[mem_idx][7:0] <= SRAM_DQ[7:0];
    end
  end

  rd_entry_t cap_entry;
  rd_entry_t pipe_out;
  logic      pipe_busy;

  always_comb begin
    cap_entry.state = is_read ? STAGE_VALID : STAGE_EMPTY;
    cap_entry.ub_n  = SRAM_UB_N;
    cap_entry.lb_n  = SRAM_LB_N;
    cap_entry.data  = mem_q[mem_idx];
  end

  sram_rd_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (is_write),
    .in_entry (cap_entry),
    .out_entry(pipe_out),
    .busy     (pipe_busy)
  );

  // Drive FSM: the final pipeline stage, holding DRIVE for one cycle per read.
  drive_state_e             drive_state_q, drive_state_d;
  logic [SRAM_DATA_LEN-1:0] drive_data_q, drive_data_d;
  logic                     drive_ub_n_q, drive_ub_n_d;
  logic                     drive_lb_n_q, drive_lb_n_d;
  logic                     dq_oe_hi;
  logic                     dq_oe_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      drive_state_q <= DRV_IDLE;
    end else begin
      drive_state_q <= drive_state_d;
    end
    drive_data_q <= drive_data_d;
    drive_ub_n_q <= drive_ub_n_d;
    drive_lb_n_q <= drive_lb_n_d;
  end

  always_comb begin
    drive_state_d = DRV_IDLE;
    if (!is_write && pipe_out.state == STAGE_VALID) begin
      drive_state_d = DRV_DRIVE;
    end
    drive_data_d = pipe_out.data;
    drive_ub_n_d = pipe_out.ub_n;
    drive_lb_n_d = pipe_out.lb_n;
  end

  always_comb begin
    dq_oe_hi = 1'b0;
    dq_oe_lo = 1'b0;
    if (drive_state_q == DRV_DRIVE && cmd == CMD_READ) begin
      dq_oe_hi = !drive_ub_n_q;
      dq_oe_lo = !drive_lb_n_q;
    end
  end

  assign SRAM_DQ[15:8] = dq_oe_hi ? drive_data_q[15:8] : 8'bz;
  assign SRAM_DQ[7:0]  = dq_oe_lo ? drive_data_q[7:0]  : 8'bz;

  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q + 16'(is_read);
    wr_count_d = wr_count_q + 16'(is_write);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

`ifdef SRAM_PROTOCOL_CHECK_EN
  logic       x_event;
  logic [1:0] viol_events;
  logic [8:0] vcount_sum;
  logic       violation_q, violation_d;
  logic [7:0] vcount_q, vcount_d;

  always_comb begin
    x_event = 1'b0;
`ifndef SYNTHESIS
    // DQ is only an input while writing; during reads it legitimately floats.
    x_event = !rst && (SRAM_CE_N === 1'b0) &&
              ($isunknown({SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_OE_N}) ||
               ((SRAM_WE_N === 1'b0) && $isunknown(SRAM_DQ)));
`endif
    viol_events = 2'(is_write && pipe_busy) + 2'(is_write && !SRAM_OE_N) + 2'(x_event);
    vcount_sum  = {1'b0, vcount_q} + 9'(viol_events);
    vcount_d    = vcount_sum[8] ? 8'hFF : vcount_sum[7:0];
    violation_d = violation_q || (viol_events != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      violation_q <= 1'b0;
      vcount_q    <= '0;
    end else begin
      violation_q <= violation_d;
      vcount_q    <= vcount_d;
    end
  end

  assign violation       = violation_q;
  assign violation_count = vcount_q;
`else
  logic unused_pipe_busy;
  assign unused_pipe_busy = pipe_busy;
  assign violation        = 1'b0;
  assign violation_count  = 8'd0;
`endif

endmodule
